// File: rtl/poke_ctl_mq.sv
// poke_ctl_mq: AXI4-Lite control block feeding up to NCH poke engines from a
// DEPTH-entry command queue, with repeat-count bursts that step the entry.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   row/entry/value     shared poke buses (hold last issued values)
//   start[NCH]          one-cycle start pulse to the selected engine
//   busy[NCH]           per-engine busy
//   S_AXI_*             AXI4-Lite slave (registers at address[AW-1:2])
//
// Register map: 0 ROW, 1 ENTRY, 2 VALUE, 3 COUNT, 4 CHAN,
//   5 CTRL (wr: bit0 enqueue, bit1 flush) / STATUS (rd), 6 ERRCNT.
module poke_ctl_mq #(
  parameter int AW          = 8,
  parameter int NCH         = 4,
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  output logic [31:0]    row,
  output logic [31:0]    entry,
  output logic [31:0]    value,
  output logic [NCH-1:0] start,
  input  logic [NCH-1:0] busy,
  input  logic [AW-1:0]  S_AXI_AWADDR,
  input  logic [2:0]     S_AXI_AWPROT,
  input  logic           S_AXI_AWVALID,
  output logic           S_AXI_AWREADY,
  input  logic [31:0]    S_AXI_WDATA,
  input  logic [3:0]     S_AXI_WSTRB,
  input  logic           S_AXI_WVALID,
  output logic           S_AXI_WREADY,
  output logic [1:0]     S_AXI_BRESP,
  output logic           S_AXI_BVALID,
  input  logic           S_AXI_BREADY,
  input  logic [AW-1:0]  S_AXI_ARADDR,
  input  logic [2:0]     S_AXI_ARPROT,
  input  logic           S_AXI_ARVALID,
  output logic           S_AXI_ARREADY,
  output logic [31:0]    S_AXI_RDATA,
  output logic [1:0]     S_AXI_RRESP,
  output logic           S_AXI_RVALID,
  input  logic           S_AXI_RREADY
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int QW = $clog2(DEPTH);
  localparam int PW = QW + 1;
  localparam int IW = AW - 2;

  localparam logic [IW-1:0] IDX_ROW   = (IW)'(0);
  localparam logic [IW-1:0] IDX_ENTRY = (IW)'(1);
  localparam logic [IW-1:0] IDX_VALUE = (IW)'(2);
  localparam logic [IW-1:0] IDX_COUNT = (IW)'(3);
  localparam logic [IW-1:0] IDX_CHAN  = (IW)'(4);
  localparam logic [IW-1:0] IDX_CTRL  = (IW)'(5);
  localparam logic [IW-1:0] IDX_ERR   = (IW)'(6);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_DONE, S_NEXT} state_t;

  // ---------------- AXI write channel ----------------
  logic          wr_stb, wr_pend_q, bvalid_q;
  logic [IW-1:0] wa_q;
  logic [31:0]   wd_q;
  logic [1:0]    bresp_q, wr_resp;

  assign wr_stb        = S_AXI_AWVALID & S_AXI_WVALID & ~wr_pend_q & ~bvalid_q;
  assign S_AXI_AWREADY = wr_stb;
  assign S_AXI_WREADY  = wr_stb;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend_q <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wr_pend_q <= wr_stb;
      if (wr_stb) begin
        wa_q <= S_AXI_AWADDR[AW-1:2];
        wd_q <= S_AXI_WDATA;
      end
      if (wr_pend_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // ---------------- registers and queue ----------------
  logic [31:0]   reg_row_q, reg_entry_q, reg_value_q, errcnt_q;
  logic [15:0]   reg_count_q;
  logic [CW-1:0] reg_chan_q;

  logic [CW-1:0] q_chan  [DEPTH];
  logic [31:0]   q_row   [DEPTH];
  logic [31:0]   q_entry [DEPTH];
  logic [31:0]   q_value [DEPTH];
  logic [15:0]   q_count [DEPTH];

  logic [PW-1:0] wptr_q, rptr_q, wptr_d, rptr_d, wbase, level;
  logic          q_full, q_empty;
  logic          chan_bad, flush_now, enq_req, enq_ok, enq_rej, err_clr;
  logic          pop, last, go;

  state_t state_q, state_d;

  assign level     = wptr_q - rptr_q;
  assign q_full    = (level == PW'(DEPTH));
  assign q_empty   = (level == '0);
  assign chan_bad  = (wd_q >= 32'(NCH));
  assign flush_now = wr_pend_q && (wa_q == IDX_CTRL) && wd_q[1];
  assign enq_req   = wr_pend_q && (wa_q == IDX_CTRL) && wd_q[0];
  // A flush frees the queue first, so a combined flush+enqueue never sees full.
  assign enq_ok    = enq_req && (flush_now || !q_full);
  assign enq_rej   = enq_req && !enq_ok;
  assign err_clr   = wr_pend_q && (wa_q == IDX_ERR);

  always_comb begin
    wr_resp = RESP_OKAY;
    case (wa_q)
      IDX_ROW, IDX_ENTRY, IDX_VALUE, IDX_COUNT, IDX_ERR: wr_resp = RESP_OKAY;
      IDX_CHAN: if (chan_bad) wr_resp = RESP_SLVERR;
      IDX_CTRL: if (enq_rej) wr_resp = RESP_SLVERR;
      default:  wr_resp = RESP_DECERR;
    endcase
  end

  // Flush keeps only the head that the dispatcher has already latched; when
  // that head is popped in the same cycle, rptr+1 is also the new read pointer.
  always_comb begin
    wbase = wptr_q;
    if (flush_now) wbase = (state_q != S_IDLE) ? rptr_q + 1'b1 : rptr_q;
    wptr_d = enq_ok ? wbase + 1'b1 : wbase;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_row_q   <= '0;
      reg_entry_q <= '0;
      reg_value_q <= '0;
      reg_count_q <= '0;
      reg_chan_q  <= '0;
      errcnt_q    <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      if (wr_pend_q) begin
        case (wa_q)
          IDX_ROW:   reg_row_q   <= wd_q;
          IDX_ENTRY: reg_entry_q <= wd_q;
          IDX_VALUE: reg_value_q <= wd_q;
          IDX_COUNT: reg_count_q <= wd_q[15:0];
          IDX_CHAN:  if (!chan_bad) reg_chan_q <= wd_q[CW-1:0];
          default: ;
        endcase
      end
      if (err_clr) errcnt_q <= '0;
      else if (enq_rej && (errcnt_q != '1)) errcnt_q <= errcnt_q + 1'b1;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) begin
      q_chan[wbase[QW-1:0]]  <= reg_chan_q;
      q_row[wbase[QW-1:0]]   <= reg_row_q;
      q_entry[wbase[QW-1:0]] <= reg_entry_q;
      q_value[wbase[QW-1:0]] <= reg_value_q;
      q_count[wbase[QW-1:0]] <= reg_count_q;
    end
  end

  // ---------------- dispatcher ----------------
  logic [CW-1:0] w_chan_q;
  logic [31:0]   w_row_q, w_entry_q, w_value_q;
  logic [31:0]   l_row_q, l_entry_q, l_value_q;
  logic [15:0]   rem_q;
  logic [7:0]    timer_q;
  logic          term_q;

  assign go   = !q_empty && !flush_now;
  assign last = (rem_q == 16'd1) || term_q || flush_now;
  assign pop  = (state_q == S_NEXT) && last;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_ISSUE;
      S_ISSUE: state_d = S_ACK;
      S_ACK: begin
        if (busy[w_chan_q]) state_d = S_DONE;
        else if (timer_q == 8'(ACK_TIMEOUT - 1)) state_d = S_NEXT;
      end
      S_DONE:  if (!busy[w_chan_q]) state_d = S_NEXT;
      S_NEXT:  state_d = last ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start = '0;
    row   = l_row_q;
    entry = l_entry_q;
    value = l_value_q;
    if (state_q == S_ISSUE) begin
      start = NCH'(1) << w_chan_q;
      row   = w_row_q;
      entry = w_entry_q;
      value = w_value_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_chan_q  <= '0;
      w_row_q   <= '0;
      w_entry_q <= '0;
      w_value_q <= '0;
      l_row_q   <= '0;
      l_entry_q <= '0;
      l_value_q <= '0;
      rem_q     <= '0;
      timer_q   <= '0;
      term_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (go) begin
          w_chan_q  <= q_chan[rptr_q[QW-1:0]];
          w_row_q   <= q_row[rptr_q[QW-1:0]];
          w_entry_q <= q_entry[rptr_q[QW-1:0]];
          w_value_q <= q_value[rptr_q[QW-1:0]];
          rem_q     <= (q_count[rptr_q[QW-1:0]] == '0) ? 16'd1 : q_count[rptr_q[QW-1:0]];
        end
        S_ISSUE: begin
          timer_q   <= '0;
          l_row_q   <= w_row_q;
          l_entry_q <= w_entry_q;
          l_value_q <= w_value_q;
        end
        S_ACK: timer_q <= timer_q + 1'b1;
        S_NEXT: if (!last) begin
          rem_q     <= rem_q - 1'b1;
          w_entry_q <= w_entry_q + 1'b1;
        end
        default: ;
      endcase
      if (state_q == S_NEXT) term_q <= 1'b0;
      else if (flush_now && (state_q != S_IDLE)) term_q <= 1'b1;
    end
  end

  // ---------------- AXI read channel ----------------
  logic          rd_stb, rvalid_q;
  logic [31:0]   rdata_q, rd_data;
  logic [1:0]    rresp_q, rd_resp;
  logic [IW-1:0] ra_idx;

  assign ra_idx        = S_AXI_ARADDR[AW-1:2];
  assign rd_stb        = S_AXI_ARVALID & ~rvalid_q;
  assign S_AXI_ARREADY = ~rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ra_idx)
      IDX_ROW:   rd_data = reg_row_q;
      IDX_ENTRY: rd_data = reg_entry_q;
      IDX_VALUE: rd_data = reg_value_q;
      IDX_COUNT: rd_data = {16'd0, reg_count_q};
      IDX_CHAN:  rd_data = 32'(reg_chan_q);
      IDX_CTRL:  rd_data = {16'(busy), 8'(level), 5'd0, q_empty, q_full, (state_q != S_IDLE)};
      IDX_ERR:   rd_data = errcnt_q;
      default:   rd_resp = RESP_DECERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (rd_stb) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_poke_ctl_mq.sv
module tb_poke_ctl_mq;

  localparam int AW = 8;
  localparam int NCH = 4;
  localparam int DEPTH = 8;
  localparam int TO = 16;

  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam int M_RESP = 0;
  localparam int M_NONE = 1;
  localparam int M_HOLD = 2;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] row, entry, value;
  logic [NCH-1:0] start, busy;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  int n_cmp = 0;
  int n_err = 0;
  int mode = M_RESP;
  int blen = 3;
  int bcnt = 0;
  logic [NCH-1:0] bmask = '0;
  int cyc = 0;
  int np = 0;
  logic [NCH-1:0] p_start [64];
  logic [31:0] p_row [64];
  logic [31:0] p_entry [64];
  logic [31:0] p_val [64];
  int p_cyc [64];

  always #5 clk = ~clk;

  poke_ctl_mq #(.AW(AW), .NCH(NCH), .DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .row(row), .entry(entry), .value(value), .start(start), .busy(busy),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Engine model and start-pulse recorder, sampled 1 time unit after each edge.
  initial begin
    busy = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        bcnt = 0;
        busy = '0;
      end else if (mode == M_HOLD) begin
        busy = '1;
      end else if (mode == M_NONE) begin
        busy = '0;
      end else if (bcnt > 0) begin
        busy = bmask;
        bcnt--;
      end else begin
        busy = '0;
      end
      if (start != '0) begin
        if (np < 64) begin
          p_start[np] = start;
          p_row[np] = row;
          p_entry[np] = entry;
          p_val[np] = value;
          p_cyc[np] = cyc;
        end
        np++;
        if (mode == M_RESP) begin
          bcnt = blen;
          bmask = start;
        end
      end
    end
  end

  task automatic wr(input int idx, input logic [31:0] d, output logic [1:0] resp);
    int n;
    awaddr = AW'(idx * 4);
    wdata = d;
    awvalid = 1'b1;
    wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) chk("b_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
  endtask

  task automatic rd(input int idx, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = AW'(idx * 4);
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) chk("r_timeout", 32'(rvalid), 32'd1);
    d = rdata;
    resp = rresp;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    logic [1:0] r;
    s = '0;
    for (int i = 0; i < 100; i++) begin
      rd(5, s, r);
      if ((s & 32'h7) == 32'h4) break;
    end
    chk(tag, s, 32'h4);
  endtask

  logic [31:0] d;
  logic [1:0] r;
  int n0;

  initial begin
    reset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = 4'hF; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_row", row, 32'd0);
    for (int i = 0; i < 7; i++) begin
      rd(i, d, r);
      chk($sformatf("rst_reg%0d", i), d, (i == 5) ? 32'h4 : 32'h0);
    end

    // single poke
    np = 0;
    wr(0, 32'd5, r); wr(1, 32'd10, r); wr(2, 32'hAB, r);
    wr(4, 32'd2, r); chk("chan_ok", 32'(r), 32'(OKAY));
    wr(3, 32'd0, r);
    wr(5, 32'd1, r); chk("t1_enq_resp", 32'(r), 32'(OKAY));
    wait_idle("t1_status");
    chk("t1_npulse", np, 1);
    chk("t1_start", 32'(p_start[0]), 32'h4);
    chk("t1_row", p_row[0], 32'd5);
    chk("t1_entry", p_entry[0], 32'd10);
    chk("t1_value", p_val[0], 32'hAB);
    chk("t1_hold_entry", entry, 32'd10);

    // burst with entry wrap, each poke after busy falls
    np = 0;
    wr(3, 32'd3, r); wr(1, 32'hFFFF_FFFF, r); wr(5, 32'd1, r);
    wait_idle("t2_status");
    chk("t2_npulse", np, 3);
    chk("t2_entry0", p_entry[0], 32'hFFFF_FFFF);
    chk("t2_entry1", p_entry[1], 32'h0);
    chk("t2_entry2", p_entry[2], 32'h1);
    chk("t2_gap01", p_cyc[1] - p_cyc[0], 6);
    chk("t2_gap12", p_cyc[2] - p_cyc[1], 6);

    // engine never answers: timeout spacing
    mode = M_NONE;
    np = 0;
    wr(3, 32'd2, r); wr(1, 32'd100, r); wr(5, 32'd1, r);
    wait_idle("t3_status");
    chk("t3_npulse", np, 2);
    chk("t3_gap", p_cyc[1] - p_cyc[0], TO + 2);
    chk("t3_entry1", p_entry[1], 32'd101);

    // queue full while the engine holds busy
    mode = M_HOLD;
    np = 0;
    wr(3, 32'd0, r);
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr(5, 32'd1, r);
      chk($sformatf("t4_enq%0d", i), 32'(r), (i < DEPTH) ? 32'(OKAY) : 32'(SLVERR));
    end
    rd(6, d, r); chk("t4_errcnt", d, 32'd2);
    rd(5, d, r); chk("t4_status_full", d, 32'h000F_0803);
    wr(6, 32'h1234, r); chk("t4_errclr_resp", 32'(r), 32'(OKAY));
    rd(6, d, r); chk("t4_errcnt_clr", d, 32'd0);
    wr(5, 32'd2, r); chk("t4_flush_resp", 32'(r), 32'(OKAY));
    mode = M_RESP;
    wait_idle("t4_status_idle");
    chk("t4_npulse", np, 1);

    // flush during a long burst
    blen = 8;
    np = 0;
    wr(3, 32'd5, r); wr(1, 32'h200, r);
    for (int i = 0; i < 4; i++) wr(5, 32'd1, r);
    wr(5, 32'd2, r);
    n0 = np;
    wait_idle("t5_status");
    chk("t5_partial", 32'((n0 >= 1) && (n0 < 5)), 32'd1);
    chk("t5_no_more", np, n0);
    chk("t5_last_entry", p_entry[(n0 > 0) ? n0 - 1 : 0], 32'h200 + 32'(n0) - 32'd1);
    blen = 3;

    // bad channel, undecoded index
    wr(4, 32'(NCH), r); chk("chan_bad_resp", 32'(r), 32'(SLVERR));
    rd(4, d, r); chk("chan_keep", d, 32'd2);
    rd(9, d, r); chk("rd_decerr", 32'(r), 32'(DECERR));
    wr(9, 32'd1, r); chk("wr_decerr", 32'(r), 32'(DECERR));

    // reset mid-burst
    np = 0;
    wr(3, 32'd5, r); wr(1, 32'd7, r); wr(5, 32'd1, r);
    for (int i = 0; i < 200 && np < 2; i++) begin @(posedge clk); #1; end
    chk("t6_started", 32'(np >= 2), 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n0 = np;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_pulse", np, n0);
    chk("t6_row", row, 32'd0);
    chk("t6_entry", entry, 32'd0);
    chk("t6_value", value, 32'd0);
    for (int i = 0; i < 7; i++) begin
      rd(i, d, r);
      chk($sformatf("t6_reg%0d", i), d, (i == 5) ? 32'h4 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
